// File: rtl/bus_cross_domain_tx.sv
// bus_cross_domain_tx
// Source side of a two-phase toggle handshake carrying an N-bit word out of
// the clkA domain. The word is registered onto DataOut_clkA, the request
// toggle is flipped, and the block waits until the synchronized acknowledge
// toggle returns to the same level as the request.
//
// Optional feature: define BUS_CROSS_TX_TIMEOUT_EN to add a WAIT_ACK timeout
// that moves the block into a terminal ERROR state and raises Error_clkA.
//
// Handshake (clkA side): a word transfers on a posedge where both
// Valid_clkA and Ready_clkA are 1. Ready_clkA depends only on internal state,
// never on Valid_clkA. Valid_clkA is ignored while Ready_clkA is 0.
module bus_cross_domain_tx #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic         clkA,
  input  logic         resetA_n,
  input  logic [N-1:0] DataIn_clkA,
  input  logic         Valid_clkA,
  output logic         Ready_clkA,
  output logic         Done_clkA,
  output logic [N-1:0] DataOut_clkA,
  output logic         ReqToggle_clkA,
  input  logic         AckToggle_clkB,
  output logic         Error_clkA,
  output logic [1:0]   StateDbg_clkA
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
`ifdef BUS_CROSS_TX_TIMEOUT_EN
  localparam logic [1:0] ERROR    = 2'd2;
  localparam int         CNT_W    = $clog2(TIMEOUT + 1);
`endif

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] ackSync;
  logic                   ackS;
  logic                   readyReg;
  logic                   doneReg;
  logic [N-1:0]           dataReg;
  logic                   reqReg;

  // Acknowledge synchronizer: shift the asynchronous ack toggle into clkA.
  always_ff @(posedge clkA or negedge resetA_n) begin
    if (!resetA_n) begin
      ackSync <= '0;
    end else begin
      ackSync <= {ackSync[SYNC_STAGES-2:0], AckToggle_clkB};
    end
  end

  assign ackS = ackSync[SYNC_STAGES-1];

`ifdef BUS_CROSS_TX_TIMEOUT_EN
  logic [CNT_W-1:0] waitCnt;
  logic             errorReg;
`endif

  // Transfer FSM: accept in IDLE, hold word and request level in WAIT_ACK,
  // complete when the synchronized ack level equals the request level.
  always_ff @(posedge clkA or negedge resetA_n) begin
    if (!resetA_n) begin
      state    <= IDLE;
      readyReg <= 1'b1;
      doneReg  <= 1'b0;
      dataReg  <= '0;
      reqReg   <= 1'b0;
`ifdef BUS_CROSS_TX_TIMEOUT_EN
      waitCnt  <= '0;
      errorReg <= 1'b0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid_clkA) begin
            dataReg  <= DataIn_clkA;
            reqReg   <= ~reqReg;
            state    <= WAIT_ACK;
            readyReg <= 1'b0;
`ifdef BUS_CROSS_TX_TIMEOUT_EN
            waitCnt  <= '0;
`endif
          end
        end
        WAIT_ACK: begin
          // A match on the timeout edge still completes the transfer.
          if (ackS == reqReg) begin
            state    <= IDLE;
            readyReg <= 1'b1;
            doneReg  <= 1'b1;
          end
`ifdef BUS_CROSS_TX_TIMEOUT_EN
          else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
            state    <= ERROR;
            errorReg <= 1'b1;
          end else begin
            waitCnt  <= waitCnt + 1'b1;
          end
`endif
        end
`ifdef BUS_CROSS_TX_TIMEOUT_EN
        ERROR: begin
          // Terminal until reset; all inputs ignored.
          state <= ERROR;
        end
`endif
        default: begin
          state    <= IDLE;
          readyReg <= 1'b1;
        end
      endcase
    end
  end

  assign Ready_clkA     = readyReg;
  assign Done_clkA      = doneReg;
  assign DataOut_clkA   = dataReg;
  assign ReqToggle_clkA = reqReg;
  assign StateDbg_clkA  = state;

`ifdef BUS_CROSS_TX_TIMEOUT_EN
  assign Error_clkA = errorReg;
`else
  assign Error_clkA = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cross_domain_tx.sv
// Bench for bus_cross_domain_tx: directed steps plus a randomized phase,
// checked against a transaction-level reference model.
module tb_bus_cross_domain_tx;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int TO = 16;
`ifdef BUS_CROSS_TX_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  // clock / reset
  logic         clkA = 1'b0;
  logic         resetA_n;
  logic [W-1:0] DataIn_clkA;
  logic         Valid_clkA;
  logic         Ready_clkA;
  logic         Done_clkA;
  logic [W-1:0] DataOut_clkA;
  logic         ReqToggle_clkA;
  logic         AckToggle_clkB;
  logic         Error_clkA;
  logic [1:0]   StateDbg_clkA;

  always #5 clkA = ~clkA;

  bus_cross_domain_tx #(.N(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clkA(clkA),
    .resetA_n(resetA_n),
    .DataIn_clkA(DataIn_clkA),
    .Valid_clkA(Valid_clkA),
    .Ready_clkA(Ready_clkA),
    .Done_clkA(Done_clkA),
    .DataOut_clkA(DataOut_clkA),
    .ReqToggle_clkA(ReqToggle_clkA),
    .AckToggle_clkB(AckToggle_clkB),
    .Error_clkA(Error_clkA),
    .StateDbg_clkA(StateDbg_clkA)
  );

  int total = 0;
  int bad   = 0;

  // reference model: a word is outstanding from acceptance until the ack
  // level seen SS edges late equals the request level
  bit           mBusy, mReq, mDone, mErr, mAccept;
  logic [W-1:0] mData;
  int           mWait;
  bit           hist[$];
  logic [W-1:0] exp_q[$];

  // receiver model
  bit autoAck = 1'b0;
  bit lastReq = 1'b0;
  int ackCnt  = 0;
  int doneCnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mBusy = 0; mReq = 0; mDone = 0; mErr = 0; mAccept = 0; mData = '0; mWait = 0;
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(1'b0);
    exp_q.delete();
  endtask

  task automatic model_step();
    bit ackPre;
    ackPre = hist[0];
    void'(hist.pop_front());
    hist.push_back(AckToggle_clkB);
    mDone = 0; mAccept = 0;
    if (!mBusy) begin
      if (Valid_clkA) begin
        mData = DataIn_clkA; mReq = ~mReq; mBusy = 1; mWait = 0; mAccept = 1;
        exp_q.push_back(DataIn_clkA);
      end
    end else if (!mErr) begin
      if (ackPre == mReq) begin
        mBusy = 0; mDone = 1;
      end else if (TIMEOUT_ON) begin
        mWait++;
        if (mWait == TO) mErr = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ready"}, 32'(Ready_clkA), 32'(!mBusy));
    check({tag, ".done"},  32'(Done_clkA),  32'(mDone));
    check({tag, ".data"},  32'(DataOut_clkA), 32'(mData));
    check({tag, ".req"},   32'(ReqToggle_clkA), 32'(mReq));
    check({tag, ".err"},   32'(Error_clkA), 32'(mErr));
  endtask

  // one clkA cycle: model follows the edge, outputs sampled 1 time unit later
  task automatic tick(input string tag);
    logic [W-1:0] e;
    @(posedge clkA);
    if (!resetA_n) model_reset(); else model_step();
    #1;
    check_outputs(tag);
    if (mDone) begin
      doneCnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, ".sb"}, 32'(DataOut_clkA), 32'(e));
      end else begin
        check({tag, ".sb_empty"}, 32'(exp_q.size()), 32'd1);
      end
    end
    if (autoAck) begin
      if (ReqToggle_clkA !== lastReq) begin
        lastReq = ReqToggle_clkA;
        ackCnt  = 5;
      end else if (ackCnt > 0) begin
        ackCnt--;
        if (ackCnt == 0) AckToggle_clkB = lastReq;
      end
    end
  endtask

  task automatic do_reset();
    resetA_n = 1'b0;
    AckToggle_clkB = 1'b0;
    Valid_clkA = 1'b0;
    model_reset();
    #1;
    check_outputs("reset_async");
    tick("reset");
    tick("reset");
    resetA_n = 1'b1;
  endtask

  logic [W-1:0] words [3];
  logic         reqSeen [3];
  int           idx;
  bit           prevDone;
  int           n;

  initial begin
    resetA_n = 1'b0;
    DataIn_clkA = '0;
    Valid_clkA = 1'b0;
    AckToggle_clkB = 1'b0;
    model_reset();
    tick("init");
    resetA_n = 1'b1;
    tick("init");

    // single transfer
    DataIn_clkA = 8'hA5; Valid_clkA = 1'b1;
    tick("single_acc");
    check("single_data", 32'(DataOut_clkA), 32'hA5);
    check("single_req",  32'(ReqToggle_clkA), 32'd1);
    check("single_rdy",  32'(Ready_clkA), 32'd0);
    Valid_clkA = 1'b0;
    AckToggle_clkB = 1'b1;
    tick("single_w");
    tick("single_w");
    check("single_rdy_early", 32'(Ready_clkA), 32'd0);
    tick("single_done");
    check("single_rdy_late", 32'(Ready_clkA), 32'd1);
    check("single_done_pulse", 32'(Done_clkA), 32'd1);
    check("single_data_held", 32'(DataOut_clkA), 32'hA5);
    tick("single_after");
    check("single_done_1cyc", 32'(Done_clkA), 32'd0);

    // reset in the middle of WAIT_ACK
    DataIn_clkA = 8'h3C; Valid_clkA = 1'b1;
    tick("mid_acc");
    Valid_clkA = 1'b0;
    tick("mid_wait");
    do_reset();
    check("mid_rst_req", 32'(ReqToggle_clkA), 32'd0);

    // back-to-back with receiver acking 5 cycles after each toggle
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    doneCnt = 0; idx = 0; prevDone = 0;
    lastReq = ReqToggle_clkA; ackCnt = 0; autoAck = 1'b1;
    DataIn_clkA = words[0]; Valid_clkA = 1'b1;
    for (int c = 0; c < 200 && doneCnt < 3; c++) begin
      tick("b2b");
      if (mAccept && idx < 3) begin
        reqSeen[idx] = ReqToggle_clkA;
        if (idx > 0) check("b2b_acc_on_done", 32'(prevDone), 32'd1);
        idx++;
        if (idx < 3) DataIn_clkA = words[idx]; else Valid_clkA = 1'b0;
      end
      prevDone = Done_clkA;
    end
    autoAck = 1'b0;
    check("b2b_dones", 32'(doneCnt), 32'd3);
    check("b2b_req0", 32'(reqSeen[0]), 32'd1);
    check("b2b_req1", 32'(reqSeen[1]), 32'd0);
    check("b2b_req2", 32'(reqSeen[2]), 32'd1);

    // hold during wait: data keeps changing with Valid high
    Valid_clkA = 1'b1;
    DataIn_clkA = 8'h5A;
    tick("hold_acc");
    for (int c = 0; c < 8; c++) begin
      DataIn_clkA = W'($urandom);
      tick("hold");
      check("hold_data", 32'(DataOut_clkA), 32'h5A);
    end
    AckToggle_clkB = ReqToggle_clkA;
    Valid_clkA = 1'b0;
    for (int c = 0; c < 6; c++) tick("hold_rel");

    // spurious ack in IDLE, then a transfer that completes early
    do_reset();
    AckToggle_clkB = 1'b1;
    doneCnt = 0;
    for (int c = 0; c < 4; c++) tick("spur_idle");
    check("spur_no_done", 32'(doneCnt), 32'd0);
    Valid_clkA = 1'b1; DataIn_clkA = 8'h77;
    tick("spur_acc");
    Valid_clkA = 1'b0;
    n = 0;
    while (doneCnt == 0 && n < 10) begin
      tick("spur_wait");
      n++;
    end
    check("spur_lat_ok", 32'(n <= SS + 1), 32'd1);

    // randomized phase: random valid/data, random ack flips
    for (int c = 0; c < 400; c++) begin
      Valid_clkA = ($urandom_range(0, 2) != 0);
      DataIn_clkA = W'($urandom);
      if ($urandom_range(0, 5) == 0) AckToggle_clkB = ~AckToggle_clkB;
      tick("rand");
    end
    Valid_clkA = 1'b0;

`ifdef BUS_CROSS_TX_TIMEOUT_EN
    // timeout: never ack
    do_reset();
    Valid_clkA = 1'b1; DataIn_clkA = 8'hE1;
    tick("to_acc");
    Valid_clkA = 1'b0;
    for (int c = 0; c < TO - 1; c++) tick("to_wait");
    check("to_no_err_yet", 32'(Error_clkA), 32'd0);
    tick("to_hit");
    check("to_err", 32'(Error_clkA), 32'd1);
    check("to_rdy", 32'(Ready_clkA), 32'd0);
    AckToggle_clkB = 1'b1;
    Valid_clkA = 1'b1;
    for (int c = 0; c < 6; c++) tick("to_ignored");
    check("to_err_sticky", 32'(Error_clkA), 32'd1);
    do_reset();
    check("to_err_clr", 32'(Error_clkA), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_cross_domain_tx.md
Name: bus_cross_domain_tx

Overview:
- Source-side transmitter for moving an N-bit word from the clkA domain to a receiver in another clock domain.
- Uses a two-phase toggle handshake: holds the data word stable, toggles a request line, and waits for the receiver's acknowledge toggle, which it synchronizes internally.
- Exposes a valid/ready interface to clkA-domain logic.
- Pairs with the destination-domain capture logic in the DAQ firmware.

Parameters:
- N, 8: data word width in bits.
- SYNC_STAGES, 2: flip-flop stages in the acknowledge synchronizer; minimum 2.
- TIMEOUT, 1024: clkA cycles allowed in WAIT_ACK before an error. Used only when the optional feature is compiled in; minimum 4.

Ports:
- clkA  input  1  source-domain clock; all logic is on posedge.
- resetA_n  input  1  asynchronous active-low reset; deassertion must be synchronous to clkA externally.
- DataIn_clkA  input  N  word to transfer.
- Valid_clkA  input  1  DataIn_clkA is valid.
- Ready_clkA  output  1  block can accept a word.
- Done_clkA  output  1  one-cycle pulse when the acknowledge for the outstanding word arrives.
- DataOut_clkA  output  N  registered word presented to the destination domain; stable throughout WAIT_ACK.
- ReqToggle_clkA  output  1  request toggle to the destination domain, driven directly from a flop.
- AckToggle_clkB  input  1  acknowledge toggle from the destination domain; asynchronous to clkA.
- Error_clkA  output  1  timeout flag; tied 0 when the feature is absent.

Behaviour:
- Reset (resetA_n low, asynchronous):
  - state=IDLE; Ready_clkA=1; Done_clkA=0; DataOut_clkA=0; ReqToggle_clkA=0; Error_clkA=0.
  - All synchronizer stages=0.
- Ack synchronizer: SYNC_STAGES-deep shift register on clkA; ack_s is the last stage.
- State IDLE (Ready_clkA=1):
  - Valid_clkA=1 at a posedge accepts the word.
  - On that edge: DataOut_clkA<=DataIn_clkA, ReqToggle_clkA inverts, state<=WAIT_ACK, Ready_clkA<=0.
  - DataOut_clkA changes in the same edge as the toggle. The destination samples data only after seeing the toggle through its own synchronizer, so data is settled by then.
- State WAIT_ACK (Ready_clkA=0):
  - Valid_clkA is ignored; DataOut_clkA and ReqToggle_clkA are held.
  - At each posedge, if ack_s==ReqToggle_clkA: state<=IDLE, Ready_clkA<=1, Done_clkA<=1 for exactly one cycle.
- Latency, SYNC_STAGES=2: AckToggle_clkB changes before edge M → ack_s updates at edge M+1 → Ready_clkA and Done_clkA are high after edge M+2.
- Back-to-back: while Ready_clkA=1 and Done_clkA=1, Valid_clkA=1 accepts the next word on that edge. No idle cycle is required.
- Done_clkA never asserts in IDLE.
- Spurious ack: an AckToggle_clkB change while in IDLE is only propagated through the synchronizer; no state change.
- Mismatch rule: in WAIT_ACK, completion requires equality with the current request level only. An ack_s mismatch simply continues waiting.
- Reset mid-transfer: returns to IDLE with ReqToggle_clkA=0. The destination must also be reset so the toggle levels realign.

Optional Feature:
- Macro: BUS_CROSS_TX_TIMEOUT_EN.
- Defined:
  - A ceil(log2(TIMEOUT+1))-bit counter clears on entry to WAIT_ACK and increments each cycle in WAIT_ACK.
  - On the edge the counter reaches TIMEOUT without a match: state<=ERROR, Error_clkA<=1, Ready_clkA stays 0.
  - ERROR is terminal: Valid_clkA and AckToggle_clkB are ignored until resetA_n is asserted.
  - An ack match on the same edge as the timeout wins: the transfer completes, no error.
- Undefined: no counter, no ERROR state, Error_clkA tied 0, WAIT_ACK waits indefinitely.

Test Plan:
- Reset: assert resetA_n=0 mid-WAIT_ACK, AckToggle_clkB=0 → same cycle Ready=1, Req=0, DataOut=0, Done=0, Error=0.
- Single transfer:
  - Valid=1 with DataIn=0xA5 → next cycle DataOut=0xA5, Req=1, Ready=0.
  - Drive AckToggle=1 → Ready=1 and Done pulse exactly 2 edges after the first sampling edge; DataOut stays 0xA5.
- Back-to-back:
  - Hold Valid=1 with words 0x01,0x02,0x03; receiver model acks 5 cycles after each toggle.
  - → Req toggles 1,0,1; each word accepted on its Done cycle; 3 Done pulses.
- Hold during wait: change DataIn every cycle in WAIT_ACK with Valid=1 → DataOut and Req unchanged; no acceptance until the ack.
- Spurious ack: toggle AckToggle in IDLE → no Done, Ready stays 1. The next Valid then waits for the matching level: Req=1 while ack_s is already 1, so it completes within SYNC_STAGES+1 cycles.
- Timeout (macro defined, TIMEOUT=16): Valid=1, never ack → Error=1 after 16 WAIT_ACK cycles, Ready=0; a later ack is ignored; reset clears Error.
